// File: rtl/fp_alu_seq.sv
// fp_alu_seq: multi-cycle floating-point ALU (ADD, SUB, MUL, restoring DIV)
// Word format {sign, EXP_W exponent, MAN_W fraction}. Denormal inputs flush to zero.
// Build macro FP_ALU_SEQ_RNE_EN: NORM rounds to nearest even. When it is not
// defined, results are truncated toward zero and no increment logic is built.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// EXEC  | add/sub/mul in one cycle, or one quotient bit per cycle for div
// NORM  | normalise, round, range check, special values, pack
// DONE  | result and flags held with out_valid=1 until out_ready
module fp_alu_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2:0]             op,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [3:0]             flags
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 1;   // significand with hidden bit
   localparam int AW = MAN_W + 4;   // significand plus guard/round/sticky
   localparam int MW = 2 * SW;      // normaliser width, unity at bit MW-2
   localparam int EW = EXP_W + 2;   // signed internal exponent
   localparam int LW = $clog2(MW);
   localparam int QW = MAN_W + 3;   // quotient bits
   localparam int CW = $clog2(QW);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_NORM = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [EW-1:0]    BIAS  = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic [EW-1:0]    EMAX  = EW'((1 << EXP_W) - 1);
   localparam logic [EXP_W-1:0] SHMAX = EXP_W'(MAN_W + 3);
   localparam logic [W-1:0]     QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   function automatic logic [W-1:0] inf_w(input logic s);
      return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
   endfunction

   function automatic logic [W-1:0] zero_w(input logic s);
      return {s, {(W-1){1'b0}}};
   endfunction

   logic [1:0]    state_q, state_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d;
   logic [2:0]    op_q, op_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [MW-1:0] m_q, m_d;
   logic [EW-1:0] e_q, e_d;
   logic          s_q, s_d;
   logic [QW-1:0] q_q, q_d;
   logic [SW:0]   r_q, r_d;
   logic [W-1:0]  result_q, result_d;
   logic [3:0]    flags_q, flags_d;

   // operand decode
   logic             sa, sb, sb_eff, sx;
   logic [EXP_W-1:0] ea, eb;
   logic             za, zb, ia, ib, na, nb;
   logic [SW-1:0]    siga, sigb;

   assign sa     = a_q[W-1];
   assign sb     = b_q[W-1];
   assign ea     = a_q[W-2 -: EXP_W];
   assign eb     = b_q[W-2 -: EXP_W];
   assign za     = (ea == '0);
   assign zb     = (eb == '0);
   assign ia     = (ea == '1) && (a_q[MAN_W-1:0] == '0);
   assign ib     = (eb == '1) && (b_q[MAN_W-1:0] == '0);
   assign na     = (ea == '1) && (a_q[MAN_W-1:0] != '0);
   assign nb     = (eb == '1) && (b_q[MAN_W-1:0] != '0);
   assign siga   = za ? '0 : {1'b1, a_q[MAN_W-1:0]};
   assign sigb   = zb ? '0 : {1'b1, b_q[MAN_W-1:0]};
   assign sb_eff = sb ^ (op_q == OP_SUB);
   assign sx     = sa ^ sb;

   // add/sub: order by magnitude, align the smaller operand, add or subtract
   logic             swap, big_s, sml_s;
   logic [EXP_W-1:0] big_e, sml_e, ediff, shamt;
   logic [SW-1:0]    big_sig, sml_sig;
   logic [2*AW-1:0]  wide;
   logic [AW-1:0]    aligned, big_ext;
   logic [AW:0]      sum;
   logic [MW-1:0]    m_add;

   always_comb begin
      swap    = (eb > ea) || ((eb == ea) && (sigb > siga));
      big_e   = swap ? eb : ea;
      sml_e   = swap ? ea : eb;
      big_sig = swap ? sigb : siga;
      sml_sig = swap ? siga : sigb;
      big_s   = swap ? sb_eff : sa;
      sml_s   = swap ? sa : sb_eff;
      ediff   = big_e - sml_e;
      shamt   = (ediff > SHMAX) ? SHMAX : ediff;
      wide    = {sml_sig, 3'b000, {AW{1'b0}}} >> shamt;
      aligned = {wide[2*AW-1:AW+1], wide[AW] | (|wide[AW-1:0])};
      big_ext = {big_sig, 3'b000};
      sum     = (big_s == sml_s) ? ({1'b0, big_ext} + {1'b0, aligned})
                                 : ({1'b0, big_ext} - {1'b0, aligned});
      m_add   = {sum, {(MW-AW-1){1'b0}}};
   end

   // multiply and divide datapath pieces
   logic [MW-1:0] prod, m_div;
   logic [EW-1:0] e_mul, e_div;
   logic [SW:0]   dvs, r_sub, r_next;
   logic          rge;

   always_comb begin
      prod   = {{SW{1'b0}}, siga} * {{SW{1'b0}}, sigb};
      e_mul  = {2'b00, ea} + {2'b00, eb} - BIAS;
      e_div  = {2'b00, ea} - {2'b00, eb} + BIAS;
      dvs    = {1'b0, sigb};
      rge    = (r_q >= dvs);
      r_sub  = rge ? (r_q - dvs) : r_q;
      r_next = r_sub << 1;
      m_div  = {1'b0, q_q, {(MW-QW-2){1'b0}}, |r_q};
   end

   // leading-one normalisation and optional rounding
   logic [MW-1:0]    m_n, norm;
   logic [LW-1:0]    lead;
   logic [EW-1:0]    e_n, e_r;
   logic [MAN_W-1:0] frac, frac_r;
   logic             norm_unused;
`ifdef FP_ALU_SEQ_RNE_EN
   logic             rnd_g, rnd_rs, rnd_inc, rnd_carry;
`endif

   always_comb begin
      m_n  = (op_q == OP_DIV) ? m_div : m_q;
      lead = '0;
      for (int i = 0; i < MW; i++) begin
         if (m_n[i]) lead = LW'(i);
      end
      norm = m_n << (LW'(MW - 1) - lead);
      e_n  = e_q + EW'(lead) - EW'(MW - 2);
      frac = norm[MW-2 -: MAN_W];
`ifdef FP_ALU_SEQ_RNE_EN
      rnd_g   = norm[MW-2-MAN_W];
      rnd_rs  = |norm[MW-3-MAN_W:0];
      rnd_inc = rnd_g & (rnd_rs | frac[0]);
      {rnd_carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, rnd_inc};
      e_r     = rnd_carry ? (e_n + EW'(1)) : e_n;
      norm_unused = norm[MW-1];
`else
      frac_r = frac;
      e_r    = e_n;
      norm_unused = ^{norm[MW-1], norm[MW-2-MAN_W:0]};
`endif
   end

   // special-value substitution: NaN, Inf and zero operands, reserved ops
   logic          spec;
   logic [W-1:0]  spec_res;
   logic [3:0]    spec_fl;

   always_comb begin
      spec     = 1'b1;
      spec_res = QNAN;
      spec_fl  = 4'b0000;
      if (op_q[2]) begin
         spec_fl = 4'b1000;
      end else if (na || nb) begin
         spec_fl = 4'b0000;
      end else begin
         case (op_q[1:0])
            2'b00, 2'b01: begin
               if (ia && ib && (sa != sb_eff)) spec_fl  = 4'b1000;
               else if (ia)                    spec_res = inf_w(sa);
               else if (ib)                    spec_res = inf_w(sb_eff);
               else                            spec     = 1'b0;
            end
            2'b10: begin
               if ((ia && zb) || (za && ib)) spec_fl  = 4'b1000;
               else if (ia || ib)            spec_res = inf_w(sx);
               else if (za || zb)            spec_res = zero_w(sx);
               else                          spec     = 1'b0;
            end
            default: begin
               if ((za && zb) || (ia && ib)) spec_fl = 4'b1000;
               else if (ia)                  spec_res = inf_w(sx);
               else if (zb) begin
                  spec_res = inf_w(sx);
                  spec_fl  = 4'b0100;
               end
               else if (ib || za)            spec_res = zero_w(sx);
               else                          spec     = 1'b0;
            end
         endcase
      end
   end

   // final result selection and exponent range check
   logic [W-1:0] res_fin;
   logic [3:0]   fl_fin;

   always_comb begin
      res_fin = {s_q, e_r[EXP_W-1:0], frac_r};
      fl_fin  = 4'b0000;
      if (spec) begin
         res_fin = spec_res;
         fl_fin  = spec_fl;
      end else if (m_n == '0) begin
         res_fin = '0;
      end else if (!e_r[EW-1] && (e_r >= EMAX)) begin
         res_fin = inf_w(s_q);
         fl_fin  = 4'b0010;
      end else if (e_r[EW-1] || (e_r == '0)) begin
         res_fin = zero_w(s_q);
         fl_fin  = 4'b0001;
      end
   end

   // control FSM and next-state of all registers
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      m_d      = m_q;
      e_d      = e_q;
      s_d      = s_q;
      q_d      = q_q;
      r_d      = r_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               cnt_d   = '0;
               q_d     = '0;
               r_d     = {1'b0, 1'b1, a[MAN_W-1:0]};
               flags_d = 4'b0000;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            m_d = (op_q == OP_MUL) ? prod : m_add;
            e_d = (op_q == OP_MUL) ? e_mul : (op_q == OP_DIV) ? e_div : {2'b00, big_e};
            s_d = ((op_q == OP_MUL) || (op_q == OP_DIV)) ? sx : big_s;
            if (op_q == OP_DIV) begin
               q_d   = {q_q[QW-2:0], rge};
               r_d   = r_next;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(QW - 1)) state_d = S_NORM;
            end else begin
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            result_d = res_fin;
            flags_d  = fl_fin;
            state_d  = S_DONE;
         end
         default: begin
            if (out_ready) state_d = S_IDLE;
         end
      endcase
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         m_q      <= '0;
         e_q      <= '0;
         s_q      <= 1'b0;
         q_q      <= '0;
         r_q      <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         m_q      <= m_d;
         e_q      <= e_d;
         s_q      <= s_d;
         q_q      <= q_d;
         r_q      <= r_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_fp_alu_seq.sv
// tb_fp_alu_seq: directed vectors for fp_alu_seq at default parameters
// (truncating build), plus handshake, backpressure and reset sequences.
module tb_fp_alu_seq;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int LAT_F = 2;
   localparam int LAT_D = MAN_W + 4;

   localparam logic [2:0] ADD = 3'b000;
   localparam logic [2:0] SUB = 3'b001;
   localparam logic [2:0] MUL = 3'b010;
   localparam logic [2:0] DIV = 3'b011;
   localparam logic [2:0] RSV = 3'b101;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [2:0]   op;
   logic [W-1:0] a, b, result;
   logic [3:0]   flags;

   int checks = 0;
   int errors = 0;

   fp_alu_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  fl;
      int          lat;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs[NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      in_valid = 1'b1;
      op = o;
      a = x;
      b = y;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic drain(input string name);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, " in_ready after accept"}, {31'b0, in_ready}, 32'd1);
      check({name, " out_valid after accept"}, {31'b0, out_valid}, 32'd0);
   endtask

   task automatic run_vec(input int i);
      int n;
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d in_ready busy", i), {31'b0, in_ready}, 32'd0);
      wait_out(n);
      check($sformatf("vec%0d latency", i), n, vecs[i].lat);
      check($sformatf("vec%0d result", i), result, vecs[i].res);
      check($sformatf("vec%0d flags", i), {28'b0, flags}, {28'b0, vecs[i].fl});
      drain($sformatf("vec%0d", i));
   endtask

   initial begin
      int n, busy_ready, stale;

      vecs[0]  = '{ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, LAT_F};
      vecs[1]  = '{DIV, 32'h40400000, 32'h40000000, 32'h3FC00000, 4'b0000, LAT_D};
      vecs[2]  = '{MUL, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0010, LAT_F};
      vecs[3]  = '{DIV, 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, LAT_D};
      vecs[4]  = '{ADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, LAT_F};
      vecs[5]  = '{SUB, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000, LAT_F};
      vecs[6]  = '{MUL, 32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000, LAT_F};
      vecs[7]  = '{SUB, 32'h40000000, 32'h40400000, 32'hBF800000, 4'b0000, LAT_F};
      vecs[8]  = '{RSV, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 4'b1000, LAT_F};
      vecs[9]  = '{ADD, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b0000, LAT_F};
      vecs[10] = '{MUL, 32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000, LAT_F};
      vecs[11] = '{DIV, 32'h00000000, 32'h80000000, 32'h7FC00000, 4'b1000, LAT_D};
      vecs[12] = '{DIV, 32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000, LAT_D};
      vecs[13] = '{MUL, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0001, LAT_F};
      vecs[14] = '{DIV, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, LAT_D};
      vecs[15] = '{ADD, 32'h3F800000, 32'hBF000000, 32'h3F000000, 4'b0000, LAT_F};
      vecs[16] = '{ADD, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0000, LAT_F};
      vecs[17] = '{ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0010, LAT_F};
      vecs[18] = '{SUB, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, LAT_F};
      vecs[19] = '{ADD, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000, LAT_F};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      op = '0;
      a = '0;
      b = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset in_ready", {31'b0, in_ready}, 32'd1);
      check("reset out_valid", {31'b0, out_valid}, 32'd0);
      check("reset result", result, 32'h0);
      check("reset flags", {28'b0, flags}, 32'h0);

      for (int i = 0; i < NV; i++) run_vec(i);

      // DIV with in_valid held high and different operands offered while busy
      in_valid = 1'b1;
      op = DIV;
      a = 32'h40400000;
      b = 32'h40000000;
      @(posedge clk); #1;
      op = ADD;
      a = 32'h3F800000;
      b = 32'h3F800000;
      n = 0;
      busy_ready = 0;
      while (!out_valid && n < 200) begin
         if (in_ready) busy_ready++;
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      check("held div latency", n, LAT_D);
      check("held div in_ready seen", busy_ready, 0);
      check("held div result", result, 32'h3FC00000);
      drain("held div");

      // backpressure: result held for 5 cycles with out_ready low
      issue(ADD, 32'h3F800000, 32'h40000000);
      wait_out(n);
      check("bp latency", n, LAT_F);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("bp%0d result", k), result, 32'h40400000);
         check($sformatf("bp%0d flags", k), {28'b0, flags}, 32'h0);
         check($sformatf("bp%0d out_valid", k), {31'b0, out_valid}, 32'd1);
         check($sformatf("bp%0d in_ready", k), {31'b0, in_ready}, 32'd0);
      end
      drain("bp");

      // reset in the middle of a DIV
      issue(DIV, 32'h3F800000, 32'h40400000);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst in_ready", {31'b0, in_ready}, 32'd1);
      check("midrst out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst result", result, 32'h0);
      check("midrst flags", {28'b0, flags}, 32'h0);
      stale = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid) stale++;
      end
      check("midrst stale out_valid", stale, 0);
      run_vec(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fp_alu_seq.md
Name: fp_alu_seq

Overview:
- Parametrised, multi-cycle floating-point ALU for the IEEE-754-style format {sign, EXP_W exponent, MAN_W fraction}.
- Successor to the team's combinational float ALU. Adds a hidden bit, exponent alignment, post-normalisation, special-value handling, exception flags, an iterative divider and a valid/ready handshake.
- Processes one operation at a time. Sits between the operand register file and the result bus.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, fraction field width (hidden bit excluded).
- Word width W = 1+EXP_W+MAN_W is derived, not a parameter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block idle; can accept an operation.
- op  in  3  000 ADD, 001 SUB (a-b), 010 MUL, 011 DIV (a/b), 100-111 reserved.
- a  in  W  operand A.
- b  in  W  operand B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  W  packed result.
- flags  out  4  {nv invalid, dz divide-by-zero, of overflow, uf underflow}.

Behaviour:
- Reset (synchronous, takes priority over everything, including an operation in flight):
  - state=IDLE, in_ready=1, out_valid=0, result=0, flags=0.
  - Any operation in progress is discarded.
- FSM states: IDLE, EXEC, NORM, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready (accept edge T), register a, b, op and go to EXEC.
  - EXEC, ADD/SUB/MUL/reserved: 1 cycle, then NORM.
  - EXEC, DIV: restoring division, one quotient bit per cycle, MAN_W+3 cycles (counter from 0 to MAN_W+2), then NORM.
  - NORM: 1 cycle. Normalise, round, detect exponent over/underflow, substitute special values, pack. Then DONE.
  - DONE: out_valid=1. result and flags stay stable until out_valid&out_ready, then go to IDLE.
  - in_ready rises the cycle after the output is accepted. No bypass and no overlap.
- Latency:
  - ADD/SUB/MUL/reserved: out_valid=1 from edge T+2.
  - DIV: out_valid=1 from edge T+MAN_W+4 (T+27 at default parameters).
- in_ready=0 in EXEC, NORM and DONE. in_valid in those states is ignored.
- Operand decode:
  - exp==0 is zero; denormals are flushed to signed zero.
  - exp==all-ones with frac==0 is Inf; with frac!=0 it is NaN.
  - Finite significand = {1, frac}.
- ADD/SUB:
  - SUB inverts b's sign.
  - The smaller-exponent significand is right-shifted by the exponent difference, clamped at MAN_W+3. Shifted-out bits are kept as guard/round/sticky.
  - Add or subtract the magnitudes in MAN_W+4 bits. The sign comes from the larger magnitude.
  - An exact-zero sum gives +0.
  - Normalise with a leading-one shift: left up to MAN_W+1, or right by 1 on carry-out.
- MUL:
  - Sign = Sa^Sb. Exponent = Ea+Eb-bias.
  - Product is 2*(MAN_W+1) bits; normalise by 0 or 1; the lower bits form sticky.
- DIV:
  - Sign = Sa^Sb. Exponent = Ea-Eb+bias.
  - Quotient in [0.5,2). The final remainder !=0 sets sticky.
- Internal exponent is signed, EXP_W+2 bits.
  - Result exp >= all-ones: signed Inf, of=1.
  - Result exp <= 0: signed zero, uf=1.
- Rounding: truncation (round toward zero) by default.
- Special cases (result, flags):
  - Any NaN operand: canonical NaN {0, all-ones, 1, 0...} = 0x7FC00000 at defaults; nv=0.
  - Inf-Inf (effective subtract): canonical NaN, nv=1.
  - 0*Inf: canonical NaN, nv=1.
  - 0/0 and Inf/Inf: canonical NaN, nv=1.
  - finite/0 (nonzero dividend): signed Inf, dz=1.
  - x/Inf: signed zero.
  - Inf with any other operand: signed Inf.
  - Reserved op: canonical NaN, nv=1.
- flags are valid only while out_valid=1. They are cleared on the accept edge of the next operation.

Optional Feature:
- Macro FP_ALU_SEQ_RNE_EN.
- Defined: NORM applies round-to-nearest-even using guard/round/sticky.
  - Mantissa carry-out renormalises and increments the exponent. That can overflow to Inf with of=1.
  - An exact-zero ADD/SUB result is still +0.
  - Latency is unchanged.
- Undefined: truncation only; the rounding-increment logic is not built.

Test Plan:
- ADD a=0x3F800000, b=0x40000000 -> result 0x40400000, flags 0000, out_valid from edge T+2.
- DIV a=0x40400000, b=0x40000000 -> result 0x3FC00000, out_valid at T+27 and not before. in_valid held high throughout is ignored (in_ready=0).
- MUL a=0x7F000000, b=0x40000000 -> 0x7F800000, of=1. DIV a=0xBF800000, b=0x00000000 -> 0xFF800000, dz=1.
- ADD a=0x7F800000, b=0xFF800000 -> 0x7FC00000, nv=1. SUB a=0x3F800000, b=0x3F800000 -> 0x00000000, flags 0000.
- Backpressure: ADD completes with out_ready=0 for 5 cycles -> result/flags stable, in_ready=0. out_ready=1 -> accepted, in_ready=1 the next cycle.
- rst pulsed 1 cycle at EXEC cycle 10 of a DIV -> next cycle in_ready=1, out_valid=0, result=0, flags=0. No stale result appears; a following ADD returns correctly.
